seq_controller: RTL and testbench

SEQ_CONTROLLER -- requirements
Module: seq_controller

---
 rtl/seq_controller_if.sv | 44 ++++
 rtl/seq_controller.sv | 172 +++++++++++++++++
 tb/tb_seq_controller.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/seq_controller_if.sv
// Datapath/memory strobe bundle between seq_controller (master) and the datapath (slave).
// The irq input exists only when CTRL_IRQ_EN is defined.
interface seq_controller_if #(
  parameter int OP_W = 8
);
  logic [OP_W-1:0] ir_opcode;
  logic            acc_zero;
  logic            m_ready;
`ifdef CTRL_IRQ_EN
  logic            irq;
`endif
  logic            mar_load;
  logic            pc_inc;
  logic            pc_load;
  logic            ir_load;
  logic            mdr_load;
  logic            acc_load;
  logic            mar_src;
  logic            pc_src;
  logic            m_en;
  logic            m_rw;
  logic [2:0]      alu_op;
  logic            halted;
  logic            fault;
  logic            irq_ack;

  modport master (
    output mar_load, pc_inc, pc_load, ir_load, mdr_load, acc_load,
           mar_src, pc_src, m_en, m_rw, alu_op, halted, fault, irq_ack,
    input  ir_opcode, acc_zero, m_ready
`ifdef CTRL_IRQ_EN
           , irq
`endif
  );

  modport slave (
    input  mar_load, pc_inc, pc_load, ir_load, mdr_load, acc_load,
           mar_src, pc_src, m_en, m_rw, alu_op, halted, fault, irq_ack,
    output ir_opcode, acc_zero, m_ready
`ifdef CTRL_IRQ_EN
           , irq
`endif
  );
endinterface

// File: rtl/seq_controller.sv
// Multi-cycle fetch/decode/execute control FSM with a memory-wait timeout.
// Interrupt entry and the EI opcode are compiled in only when CTRL_IRQ_EN is defined.
module seq_controller #(
  parameter int OP_W     = 8,
  parameter int WAIT_MAX = 15,
  parameter int IRQ_VEC  = 0
) (
  input logic              clk,
  input logic              rst,
  seq_controller_if.master bus
);
  localparam logic [3:0] S_F0    = 4'd0;
  localparam logic [3:0] S_F1    = 4'd1;
  localparam logic [3:0] S_DEC   = 4'd2;
  localparam logic [3:0] S_EA    = 4'd3;
  localparam logic [3:0] S_RD    = 4'd4;
  localparam logic [3:0] S_WR    = 4'd5;
  localparam logic [3:0] S_EXE   = 4'd6;
  localparam logic [3:0] S_JMP   = 4'd7;
  localparam logic [3:0] S_IRQ   = 4'd8;
  localparam logic [3:0] S_HALT  = 4'd9;
  localparam logic [3:0] S_FAULT = 4'd10;

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_EI  = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  if (OP_W < 4) begin : g_bad_op_w
    $error("seq_controller: OP_W must be at least 4");
  end
  if (WAIT_MAX < 1 || WAIT_MAX > 255) begin : g_bad_wait_max
    $error("seq_controller: WAIT_MAX must be in 1..255");
  end
  if (IRQ_VEC < 0) begin : g_bad_irq_vec
    $error("seq_controller: IRQ_VEC must be non-negative");
  end
  if (OP_W > 4) begin : g_op_lo
    logic w_unused_op_lo;
    assign w_unused_op_lo = ^bus.ir_opcode[OP_W-5:0];
  end

  logic [3:0] r_state;
  logic [3:0] w_next;
  logic [7:0] r_wcnt;
  logic [3:0] r_op;
  logic [3:0] w_op;
  logic       w_tmo;
  logic       w_irq_take;

  assign w_op  = bus.ir_opcode[OP_W-1 -: 4];
  assign w_tmo = (r_wcnt == 8'(WAIT_MAX)) && !bus.m_ready;

`ifdef CTRL_IRQ_EN
  logic r_ie;
  assign w_irq_take = bus.irq & r_ie;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                      r_ie <= 1'b0;
    else if (r_state == S_DEC && w_op == OP_EI)   r_ie <= 1'b1;
    else if (r_state == S_IRQ)                    r_ie <= 1'b0;
  end
`else
  assign w_irq_take = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_F0;
      r_wcnt  <= 8'd0;
      r_op    <= 4'd0;
    end else begin
      r_state <= w_next;
      // Only a stay in a memory state is a wait; any exit restarts the count.
      if ((r_state == S_F1 || r_state == S_RD || r_state == S_WR) && w_next == r_state)
        r_wcnt <= r_wcnt + 8'd1;
      else
        r_wcnt <= 8'd0;
      if (r_state == S_DEC)
        r_op <= w_op;
    end
  end

  always_comb begin
    w_next = S_FAULT;
    case (r_state)
      S_F0:    w_next = w_irq_take ? S_IRQ : S_F1;
      S_F1:    w_next = bus.m_ready ? S_DEC : (w_tmo ? S_FAULT : S_F1);
      S_DEC: begin
        case (w_op)
          OP_LDA, OP_STA, OP_ADD, OP_SUB: w_next = S_EA;
          OP_JMP:                         w_next = S_JMP;
          OP_JZ:                          w_next = bus.acc_zero ? S_JMP : S_F0;
          OP_HLT:                         w_next = S_HALT;
          default:                        w_next = S_F0;
        endcase
      end
      S_EA:    w_next = (r_op == OP_STA) ? S_WR : S_RD;
      S_RD:    w_next = bus.m_ready ? S_EXE : (w_tmo ? S_FAULT : S_RD);
      S_WR:    w_next = bus.m_ready ? S_F0 : (w_tmo ? S_FAULT : S_WR);
      S_EXE:   w_next = S_F0;
      S_JMP:   w_next = S_F0;
`ifdef CTRL_IRQ_EN
      S_IRQ:   w_next = S_F0;
`endif
      S_HALT:  w_next = S_HALT;
      S_FAULT: w_next = S_FAULT;
      default: w_next = S_FAULT;
    endcase
  end

  // Outputs are held low for the whole of reset, including the F0 decodes.
  always_comb begin
    bus.mar_load = 1'b0;
    bus.pc_inc   = 1'b0;
    bus.pc_load  = 1'b0;
    bus.ir_load  = 1'b0;
    bus.mdr_load = 1'b0;
    bus.acc_load = 1'b0;
    bus.mar_src  = 1'b0;
    bus.pc_src   = 1'b0;
    bus.m_en     = 1'b0;
    bus.m_rw     = 1'b0;
    bus.alu_op   = 3'd0;
    bus.halted   = 1'b0;
    bus.fault    = 1'b0;
    bus.irq_ack  = 1'b0;
    if (!rst) begin
      case (r_state)
        S_F0: begin
          bus.mar_load = !w_irq_take;
          bus.pc_inc   = !w_irq_take;
        end
        S_F1: begin
          bus.m_en    = 1'b1;
          bus.ir_load = bus.m_ready;
        end
        S_EA: begin
          bus.mar_src  = 1'b1;
          bus.mar_load = 1'b1;
        end
        S_RD: begin
          bus.m_en     = 1'b1;
          bus.mdr_load = bus.m_ready;
        end
        S_WR: begin
          bus.m_en = 1'b1;
          bus.m_rw = 1'b1;
        end
        S_EXE: begin
          bus.acc_load = 1'b1;
          bus.alu_op   = (r_op == OP_ADD) ? 3'd1 : ((r_op == OP_SUB) ? 3'd2 : 3'd0);
        end
        S_JMP:   bus.pc_load = 1'b1;
`ifdef CTRL_IRQ_EN
        S_IRQ: begin
          bus.irq_ack = 1'b1;
          bus.pc_load = 1'b1;
          bus.pc_src  = 1'b1;
        end
`endif
        S_HALT:  bus.halted = 1'b1;
        S_FAULT: bus.fault  = 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_seq_controller.sv
// Directed bench for seq_controller: per-cycle vector table plus hand-written
// wait, timeout, halt, reset-abort and (CTRL_IRQ_EN builds) interrupt sequences.
module tb_seq_controller;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_controller_if #(.OP_W(8)) bus ();

  seq_controller #(.OP_W(8), .WAIT_MAX(15), .IRQ_VEC(0)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Observed output word: ml pi pl il dl al ms ps me mw alu[2:0] h f ia
  localparam logic [15:0] ML = 16'h8000, PI = 16'h4000, PL = 16'h2000, IL = 16'h1000;
  localparam logic [15:0] DL = 16'h0800, AL = 16'h0400, MS = 16'h0200, PS = 16'h0100;
  localparam logic [15:0] ME = 16'h0080, MW = 16'h0040, A_ADD = 16'h0008, A_SUB = 16'h0010;
  localparam logic [15:0] HA = 16'h0004, FA = 16'h0002, IA = 16'h0001;
  localparam logic [15:0] F0 = ML | PI;

  logic [15:0] obs;
  assign obs = {bus.mar_load, bus.pc_inc, bus.pc_load, bus.ir_load, bus.mdr_load,
                bus.acc_load, bus.mar_src, bus.pc_src, bus.m_en, bus.m_rw,
                bus.alu_op, bus.halted, bus.fault, bus.irq_ack};

  typedef struct {
    logic [3:0]  op;
    logic        az;
    logic        mr;
    logic [15:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input logic [15:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got=%h want=%h at %0t", nm, obs, exp, $time);
    end
  endtask

  task automatic add(input logic [3:0] op, input logic az, input logic mr, input logic [15:0] exp);
    vec_t v;
    v.op = op; v.az = az; v.mr = mr; v.exp = exp;
    tbl.push_back(v);
  endtask

  // Drive one cycle's inputs just after the rising edge, check, advance.
  task automatic cyc(input string nm, input logic [3:0] op, input logic az, input logic mr,
                     input logic [15:0] exp);
    bus.ir_opcode = {op, 4'hA};
    bus.acc_zero  = az;
    bus.m_ready   = mr;
    #1;
    chk(nm, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.ir_opcode = 8'h00;
    bus.acc_zero  = 1'b0;
    bus.m_ready   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 16'h0000);
    rst = 1'b0;
  endtask

  initial begin
`ifdef CTRL_IRQ_EN
    bus.irq = 1'b0;
`endif
    // LDA / ADD / SUB: opcode bus changed to 0 after DEC to prove it was latched
    add(1,0,1,F0); add(1,0,1,ME|IL); add(1,0,1,0); add(0,0,1,ML|MS); add(0,0,1,ME|DL); add(0,0,1,AL);
    add(3,0,1,F0); add(3,0,1,ME|IL); add(3,0,1,0); add(0,0,1,ML|MS); add(0,0,1,ME|DL); add(0,0,1,AL|A_ADD);
    add(4,0,1,F0); add(4,0,1,ME|IL); add(4,0,1,0); add(0,0,1,ML|MS); add(0,0,1,ME|DL); add(0,0,1,AL|A_SUB);
    // STA, JMP, JZ taken / untaken
    add(2,0,1,F0); add(2,0,1,ME|IL); add(2,0,1,0); add(0,0,1,ML|MS); add(0,0,1,ME|MW);
    add(5,0,1,F0); add(5,0,1,ME|IL); add(5,0,1,0); add(5,0,1,PL);
    add(6,1,1,F0); add(6,1,1,ME|IL); add(6,1,1,0); add(6,1,1,PL);
    add(6,0,1,F0); add(6,0,1,ME|IL); add(6,0,1,0);
    // NOPs (0, 8, 7 which is EI only in interrupt builds)
    add(0,0,1,F0); add(0,0,1,ME|IL); add(0,0,1,0);
    add(8,0,1,F0); add(8,0,1,ME|IL); add(8,0,1,0);
    add(7,0,1,F0); add(7,0,1,ME|IL); add(7,0,1,0);
    // LDA with one wait in F1 and one in RD
    add(1,0,1,F0); add(1,0,0,ME); add(1,0,1,ME|IL); add(1,0,1,0); add(0,0,1,ML|MS);
    add(0,0,0,ME); add(0,0,1,ME|DL); add(0,0,1,AL); add(0,0,1,F0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++)
      cyc($sformatf("tbl[%0d]", i), tbl[i].op, tbl[i].az, tbl[i].mr, tbl[i].exp);

    // STA with three wait cycles in WR
    do_reset();
    cyc("sta_f0", 2,0,1,F0); cyc("sta_f1", 2,0,1,ME|IL); cyc("sta_dec", 2,0,1,0); cyc("sta_ea", 2,0,1,ML|MS);
    for (int i = 0; i < 3; i++) cyc("sta_wr_wait", 2,0,0,ME|MW);
    cyc("sta_wr_done", 2,0,1,ME|MW);
    cyc("sta_back_f0", 0,0,1,F0);

    // m_ready arriving on the last permitted wait cycle still wins
    do_reset();
    cyc("edge_f0", 0,0,0,F0);
    for (int i = 0; i < 15; i++) cyc("edge_f1_wait", 0,0,0,ME);
    cyc("edge_f1_ready", 0,0,1,ME|IL);
    cyc("edge_dec", 0,0,1,0);
    cyc("edge_back_f0", 0,0,1,F0);

    // Stuck m_ready in F1: fault on cycle 18 (17 after F0), absorbing until reset
    do_reset();
    cyc("tmo_f0", 0,0,0,F0);
    for (int i = 0; i < 16; i++) cyc("tmo_f1_wait", 0,0,0,ME);
    for (int i = 0; i < 5; i++) cyc("tmo_fault_held", 0,0,i[0],FA);
    rst = 1'b1;
    #1;
    chk("tmo_rst_clears", 16'h0000);
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("tmo_after_rst_f0", 0,0,1,F0);
    cyc("tmo_after_rst_f1", 0,0,1,ME|IL);

    // HLT: halted held for 100 cycles with no memory activity
    do_reset();
    cyc("hlt_f0", 4'hF,0,1,F0); cyc("hlt_f1", 4'hF,0,1,ME|IL); cyc("hlt_dec", 4'hF,0,1,0);
    for (int i = 0; i < 100; i++) cyc("hlt_held", 4'h1,0,1,HA);

    // Reset asserted mid-cycle in RD drops m_en immediately
    do_reset();
    cyc("rra_f0", 1,0,1,F0); cyc("rra_f1", 1,0,1,ME|IL); cyc("rra_dec", 1,0,1,0); cyc("rra_ea", 1,0,1,ML|MS);
    bus.m_ready = 1'b0;
    #1;
    chk("rra_rd_wait", ME);
    #2;
    rst = 1'b1;
    #1;
    chk("rra_m_en_drop", 16'h0000);
    @(posedge clk); #1;
    chk("rra_held_in_rst", 16'h0000);
    rst = 1'b0;
    cyc("rra_first_f0", 0,0,1,F0);
    cyc("rra_first_f1", 0,0,1,ME|IL);

`ifdef CTRL_IRQ_EN
    // EI then irq: single irq_ack, further irq ignored until the next EI
    do_reset();
    cyc("irq_pre_f0", 0,0,1,F0); cyc("irq_pre_f1", 0,0,1,ME|IL); cyc("irq_pre_dec", 0,0,1,0);
    bus.irq = 1'b1;
    cyc("irq_no_ie_f0", 0,0,1,F0); cyc("irq_no_ie_f1", 7,0,1,ME|IL); cyc("irq_ei_dec", 7,0,1,0);
    cyc("irq_take_f0", 0,0,1,0);
    cyc("irq_ack", 0,0,1,IA|PL|PS);
    cyc("irq_ignored_f0", 0,0,1,F0); cyc("irq_ignored_f1", 0,0,1,ME|IL); cyc("irq_ignored_dec", 0,0,1,0);
    cyc("irq_ignored_f0b", 0,0,1,F0); cyc("irq_ei2_f1", 7,0,1,ME|IL); cyc("irq_ei2_dec", 7,0,1,0);
    cyc("irq_take2_f0", 0,0,1,0);
    cyc("irq_ack2", 0,0,1,IA|PL|PS);
    bus.irq = 1'b0;
    cyc("irq_done_f0", 0,0,1,F0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
